// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Holds the FSM state encoding, the grant-owner enum and the watchdog fill data.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GNT_INSTR = 2'd1,
    GNT_DATA  = 2'd2
  } bus_arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } bus_arb_gnt_e;

  localparam logic [31:0] BUS_ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Round-robin pick: a tie goes to the side that did not win last time.
  function automatic bus_arb_gnt_e pick_winner(input logic instr_v,
                                               input logic data_v,
                                               input bus_arb_gnt_e last);
    bus_arb_gnt_e win;
    if (instr_v && data_v) begin
      if (last == GNT_D) win = GNT_I;
      else               win = GNT_D;
    end else if (instr_v) begin
      win = GNT_I;
    end else begin
      win = GNT_D;
    end
    return win;
  endfunction

endpackage

// File: rtl/bus_arb_watchdog.sv
// Transaction watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the LIMIT-th enabled cycle is reached.
module bus_arb_watchdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of earlier enabled cycles, so LIMIT-1 marks the LIMIT-th.
  assign expire_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin instr/data to single memory port arbiter, one transaction in flight, all outputs registered.
// Optional watchdog that completes a hung transaction with filler data: BUS_ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 19,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_valid_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  output logic              instr_ready_o,
  output logic [DATA_W-1:0] instr_read_data_o,
  input  logic              data_valid_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_write_data_i,
  input  logic [3:0]        data_wstrb_i,
  output logic              data_ready_o,
  output logic [DATA_W-1:0] data_read_data_o,
  output logic              mem_valid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  output logic [3:0]        mem_wstrb_o,
  output logic              mem_instr_o,
`ifdef BUS_ARB_TIMEOUT_EN
  output logic              timeout_err_o,
`endif
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_read_data_i
);

  bus_arb_state_e    state_q,       state_d;
  bus_arb_gnt_e      last_gnt_q,    last_gnt_d;
  logic              mem_valid_q,   mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
  logic [3:0]        mem_wstrb_q,   mem_wstrb_d;
  logic              mem_instr_q,   mem_instr_d;
  logic              instr_rdy_q,   instr_rdy_d;
  logic              data_rdy_q,    data_rdy_d;
  logic [DATA_W-1:0] instr_rdata_q, instr_rdata_d;
  logic [DATA_W-1:0] data_rdata_q,  data_rdata_d;

  bus_arb_gnt_e      win;
  logic              wd_expire;
  logic              xfer_done;
  logic [DATA_W-1:0] rsp_data;

`ifdef BUS_ARB_TIMEOUT_EN
  logic timeout_err_q;
  logic timeout_err_d;

  bus_arb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q == IDLE),
    .en_i     (state_q != IDLE),
    .expire_o (wd_expire)
  );

  // A real response in the expiry cycle wins and is not an error.
  assign timeout_err_d = timeout_err_q | (wd_expire & ~mem_ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err_o = timeout_err_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
  assign wd_expire  = 1'b0;
`endif

  assign win       = pick_winner(instr_valid_i, data_valid_i, last_gnt_q);
  assign xfer_done = mem_ready_i | wd_expire;
  assign rsp_data  = mem_ready_i ? mem_read_data_i : DATA_W'(BUS_ARB_TIMEOUT_DATA);

  always_comb begin
    state_d       = state_q;
    last_gnt_d    = last_gnt_q;
    mem_valid_d   = mem_valid_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wstrb_d   = mem_wstrb_q;
    mem_instr_d   = mem_instr_q;
    instr_rdy_d   = 1'b0;
    data_rdy_d    = 1'b0;
    instr_rdata_d = instr_rdata_q;
    data_rdata_d  = data_rdata_q;

    case (state_q)
      IDLE: begin
        if (instr_valid_i || data_valid_i) begin
          mem_valid_d = 1'b1;
          if (win == GNT_I) begin
            state_d     = GNT_INSTR;
            mem_addr_d  = instr_addr_i;
            mem_wdata_d = '0;
            mem_wstrb_d = 4'h0;
            mem_instr_d = 1'b1;
          end else begin
            state_d     = GNT_DATA;
            mem_addr_d  = data_addr_i;
            mem_wdata_d = data_write_data_i;
            mem_wstrb_d = data_wstrb_i;
            mem_instr_d = 1'b0;
          end
        end
      end

      GNT_INSTR: begin
        if (xfer_done) begin
          state_d       = IDLE;
          last_gnt_d    = GNT_I;
          mem_valid_d   = 1'b0;
          mem_instr_d   = 1'b0;
          instr_rdy_d   = 1'b1;
          instr_rdata_d = rsp_data;
        end
      end

      GNT_DATA: begin
        if (xfer_done) begin
          state_d      = IDLE;
          last_gnt_d   = GNT_D;
          mem_valid_d  = 1'b0;
          mem_instr_d  = 1'b0;
          data_rdy_d   = 1'b1;
          data_rdata_d = rsp_data;
        end
      end

      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
        mem_instr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      last_gnt_q    <= GNT_D;
      mem_valid_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wstrb_q   <= 4'h0;
      mem_instr_q   <= 1'b0;
      instr_rdy_q   <= 1'b0;
      data_rdy_q    <= 1'b0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_gnt_q    <= last_gnt_d;
      mem_valid_q   <= mem_valid_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wstrb_q   <= mem_wstrb_d;
      mem_instr_q   <= mem_instr_d;
      instr_rdy_q   <= instr_rdy_d;
      data_rdy_q    <= data_rdy_d;
      instr_rdata_q <= instr_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  assign instr_ready_o     = instr_rdy_q;
  assign instr_read_data_o = instr_rdata_q;
  assign data_ready_o      = data_rdy_q;
  assign data_read_data_o  = data_rdata_q;
  assign mem_valid_o       = mem_valid_q;
  assign mem_addr_o        = mem_addr_q;
  assign mem_write_data_o  = mem_wdata_q;
  assign mem_wstrb_o       = mem_wstrb_q;
  assign mem_instr_o       = mem_instr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic, checked every cycle against a transaction-level model.
module tb_bus_arbiter;

  localparam int AW = 19;
  localparam int DW = 32;
  localparam int TO = 16;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          instr_valid_i = 1'b0;
  logic [AW-1:0] instr_addr_i = '0;
  logic          instr_ready_o;
  logic [DW-1:0] instr_read_data_o;
  logic          data_valid_i = 1'b0;
  logic [AW-1:0] data_addr_i = '0;
  logic [DW-1:0] data_write_data_i = '0;
  logic [3:0]    data_wstrb_i = '0;
  logic          data_ready_o;
  logic [DW-1:0] data_read_data_o;
  logic          mem_valid_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_write_data_o;
  logic [3:0]    mem_wstrb_o;
  logic          mem_instr_o;
  logic          mem_ready_i = 1'b0;
  logic [DW-1:0] mem_read_data_i = '0;
`ifdef BUS_ARB_TIMEOUT_EN
  logic          timeout_err_o;
`endif

  int vecs  = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .instr_valid_i     (instr_valid_i),
    .instr_addr_i      (instr_addr_i),
    .instr_ready_o     (instr_ready_o),
    .instr_read_data_o (instr_read_data_o),
    .data_valid_i      (data_valid_i),
    .data_addr_i       (data_addr_i),
    .data_write_data_i (data_write_data_i),
    .data_wstrb_i      (data_wstrb_i),
    .data_ready_o      (data_ready_o),
    .data_read_data_o  (data_read_data_o),
    .mem_valid_o       (mem_valid_o),
    .mem_addr_o        (mem_addr_o),
    .mem_write_data_o  (mem_write_data_o),
    .mem_wstrb_o       (mem_wstrb_o),
    .mem_instr_o       (mem_instr_o),
`ifdef BUS_ARB_TIMEOUT_EN
    .timeout_err_o     (timeout_err_o),
`endif
    .mem_ready_i       (mem_ready_i),
    .mem_read_data_i   (mem_read_data_i)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one busy owner at a time, ties go to whoever did not win last.
  bit            m_busy  = 1'b0;
  bit            m_side  = 1'b0;   // 0 = instr, 1 = data
  bit            m_last  = 1'b1;
  int            m_wcnt  = 0;
  bit            m_rst   = 1'b0;
  bit            e_mvalid, e_minstr, e_iready, e_dready, e_err;
  logic [AW-1:0] e_maddr;
  logic [DW-1:0] e_mwd, e_irdata, e_drdata, rsp;
  logic [3:0]    e_mws;

  always @(posedge clk) begin
    if (rst_i) begin
      m_busy = 1'b0; m_last = 1'b1; m_rst = 1'b1;
      e_mvalid = 0; e_minstr = 0; e_iready = 0; e_dready = 0; e_err = 0;
      e_maddr = '0; e_mwd = '0; e_mws = '0; e_irdata = '0; e_drdata = '0;
    end else begin
      m_rst = 1'b0; e_iready = 0; e_dready = 0;
      if (!m_busy) begin
        if (instr_valid_i || data_valid_i) begin
          m_side   = (instr_valid_i && data_valid_i) ? !m_last : data_valid_i;
          m_busy   = 1'b1;
          m_wcnt   = 0;
          e_mvalid = 1'b1;
          e_minstr = !m_side;
          e_maddr  = m_side ? data_addr_i : instr_addr_i;
          e_mwd    = m_side ? data_write_data_i : '0;
          e_mws    = m_side ? data_wstrb_i : 4'h0;
        end
      end else begin
        m_wcnt++;
        if (mem_ready_i || (TO_EN && m_wcnt >= TO)) begin
          rsp = mem_ready_i ? mem_read_data_i : 32'hDEAD_BEEF;
          if (!mem_ready_i) e_err = 1'b1;
          m_busy = 1'b0; m_last = m_side; e_mvalid = 0; e_minstr = 0;
          if (m_side) begin e_dready = 1; e_drdata = rsp; end
          else        begin e_iready = 1; e_irdata = rsp; end
        end
      end
    end
    #1;
    chk("mem_valid", mem_valid_o, e_mvalid);
    chk("mem_instr", mem_instr_o, e_minstr);
    chk("instr_ready", instr_ready_o, e_iready);
    chk("data_ready", data_ready_o, e_dready);
    chk("instr_rdata", instr_read_data_o, e_irdata);
    chk("data_rdata", data_read_data_o, e_drdata);
    if (e_mvalid || m_rst) begin
      chk("mem_addr", mem_addr_o, e_maddr);
      chk("mem_wstrb", mem_wstrb_o, e_mws);
    end
    if ((e_mvalid && m_side) || m_rst) chk("mem_wdata", mem_write_data_o, e_mwd);
`ifdef BUS_ARB_TIMEOUT_EN
    chk("timeout_err", timeout_err_o, e_err);
`endif
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Waits for a grant, answers after wait_c extra cycles, then drops the finished side's valid.
  task automatic serve(input int wait_c, output bit was_instr);
    int t = 0;
    while (!mem_valid_o && t < 20) begin step(); t++; end
    was_instr = mem_instr_o;
    if (!mem_valid_o) begin
      chk("serve_wait_mem_valid", mem_valid_o, 1);
      return;
    end
    repeat (wait_c) step();
    mem_ready_i = 1'b1; mem_read_data_i = $urandom;
    step();
    mem_ready_i = 1'b0;
    if (instr_ready_o) instr_valid_i = 1'b0;
    if (data_ready_o)  data_valid_i  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit gi;
    int g;
    step(); step();
    chk("rst_mem_valid", mem_valid_o, 0);
    chk("rst_instr_ready", instr_ready_o, 0);
    chk("rst_data_ready", data_ready_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    rst_i = 1'b0;
    step();

    // Instr-only read, zero-wait memory.
    instr_valid_i = 1'b1; instr_addr_i = 19'h00010;
    step();
    chk("A_mem_valid", mem_valid_o, 1);
    chk("A_mem_instr", mem_instr_o, 1);
    chk("A_mem_wstrb", mem_wstrb_o, 0);
    chk("A_mem_addr", mem_addr_o, 19'h00010);
    mem_ready_i = 1'b1; mem_read_data_i = 32'h1234_5678;
    step();
    mem_ready_i = 1'b0;
    chk("A_instr_ready", instr_ready_o, 1);
    chk("A_instr_rdata", instr_read_data_o, 32'h1234_5678);
    chk("A_data_ready", data_ready_o, 0);
    chk("A_mem_valid_drop", mem_valid_o, 0);
    instr_valid_i = 1'b0;
    step();
    chk("A_ready_pulse", instr_ready_o, 0);

    // Simultaneous requests: alternation I,D,I,D...
    rst_i = 1'b1; step(); rst_i = 1'b0;
    instr_valid_i = 1'b1; instr_addr_i = 19'h00100;
    data_valid_i = 1'b1; data_addr_i = 19'h00200; data_wstrb_i = 4'h0; data_write_data_i = '0;
    step();
    for (int k = 0; k < 8; k++) begin
      serve(0, gi);
      chk("B_tie_order", gi, (k % 2 == 0));
      if (k < 7) begin
        step();
        if (!instr_valid_i) begin instr_valid_i = 1'b1; instr_addr_i = AW'($urandom); end
        if (!data_valid_i)  begin data_valid_i  = 1'b1; data_addr_i  = AW'($urandom); end
      end
    end
    serve(0, gi);
    step();

    // Data write at top of address range with a 5-cycle memory wait.
    data_valid_i = 1'b1; data_addr_i = 19'h7FFFF; data_write_data_i = 32'hA5A5_A5A5; data_wstrb_i = 4'b0011;
    step();
    for (int c = 0; c < 6; c++) begin
      chk("C_mem_valid", mem_valid_o, 1);
      chk("C_mem_addr", mem_addr_o, 19'h7FFFF);
      chk("C_mem_wdata", mem_write_data_o, 32'hA5A5_A5A5);
      chk("C_mem_wstrb", mem_wstrb_o, 4'b0011);
      chk("C_mem_instr", mem_instr_o, 0);
      chk("C_data_ready_early", data_ready_o, 0);
      if (c == 5) mem_ready_i = 1'b1;
      step();
    end
    mem_ready_i = 1'b0;
    chk("C_data_ready", data_ready_o, 1);
    chk("C_mem_valid_drop", mem_valid_o, 0);
    data_valid_i = 1'b0;
    step();
    chk("C_ready_single", data_ready_o, 0);

    // Leave last_gnt at instr, then reset in the middle of a data transaction.
    instr_valid_i = 1'b1; instr_addr_i = 19'h00020;
    serve(1, gi);
    step();
    data_valid_i = 1'b1; data_addr_i = 19'h00055; data_wstrb_i = 4'h0;
    step();
    chk("D_mem_valid", mem_valid_o, 1);
    chk("D_mem_instr", mem_instr_o, 0);
    rst_i = 1'b1; data_valid_i = 1'b0;
    step();
    rst_i = 1'b0; mem_ready_i = 1'b1;
    chk("D_rst_mem_valid", mem_valid_o, 0);
    chk("D_rst_data_ready", data_ready_o, 0);
    chk("D_rst_mem_addr", mem_addr_o, 0);
    chk("D_rst_mem_wstrb", mem_wstrb_o, 0);
    step();
    mem_ready_i = 1'b0;
    chk("D_late_ready_ignored", data_ready_o, 0);
    chk("D_idle_mem_valid", mem_valid_o, 0);
    instr_valid_i = 1'b1; instr_addr_i = 19'h00030;
    data_valid_i = 1'b1;
    step();
    chk("D_tie_after_reset", mem_instr_o, 1);
    serve(0, gi);
    serve(0, gi);
    step();

`ifdef BUS_ARB_TIMEOUT_EN
    // Memory never answers an instr read.
    instr_valid_i = 1'b1; instr_addr_i = 19'h00044;
    step();
    g = 0;
    while (mem_valid_o && g < 40) begin g++; step(); end
    chk("E_gnt_cycles", g, TO);
    chk("E_instr_ready", instr_ready_o, 1);
    chk("E_timeout_rdata", instr_read_data_o, 32'hDEAD_BEEF);
    chk("E_err_set", timeout_err_o, 1);
    instr_valid_i = 1'b0;
    step();
    chk("E_err_sticky", timeout_err_o, 1);
    rst_i = 1'b1; step(); rst_i = 1'b0;
    chk("E_err_cleared", timeout_err_o, 0);
`endif

    // Random traffic; the per-cycle model comparison does the checking.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if ($urandom_range(199) == 0) begin
        rst_i = 1'b1; instr_valid_i = 1'b0; data_valid_i = 1'b0; mem_ready_i = 1'b0;
        continue;
      end
      rst_i = 1'b0;
      if (instr_valid_i && instr_ready_o) instr_valid_i = 1'b0;
      else if (!instr_valid_i && $urandom_range(2) == 0) begin
        instr_valid_i = 1'b1; instr_addr_i = AW'($urandom);
      end
      if (data_valid_i && data_ready_o) data_valid_i = 1'b0;
      else if (!data_valid_i && $urandom_range(2) == 0) begin
        data_valid_i = 1'b1; data_addr_i = AW'($urandom);
        data_write_data_i = $urandom;
        data_wstrb_i = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
      end
      mem_ready_i     = mem_valid_o ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      mem_read_data_i = $urandom;
    end
    rst_i = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
